// File: rtl/sf_camera_capture.sv
// sf_camera_capture
// Packs 8-bit camera bytes, framed by vsync/href, into 32-bit words and
// writes them into a ping-pong FIFO channel. It also drives the DMA enable
// and keeps frame and dropped-word statistics.
module sf_camera_capture #(
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_cam_vsync,
  input  logic                 i_cam_href,
  input  logic                 i_cam_valid,
  input  logic [7:0]           i_cam_data,
  output logic                 o_enable_dma,
  input  logic [1:0]           i_wr_rdy,
  output logic [1:0]           o_wr_act,
  input  logic [23:0]          i_wr_size,
  output logic                 o_wr_stb,
  output logic [31:0]          o_wr_data,
  output logic                 o_frame_done,
  output logic [CNT_WIDTH-1:0] o_frame_count,
  output logic [CNT_WIDTH-1:0] o_overflow_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Packer: pack_cnt_reg counts bytes held (0..4); lane 0 is [31:24].
  logic [2:0]  pack_cnt_reg, pack_cnt_next;
  logic [31:0] pack_data_reg, pack_data_next;
  logic [1:0]  lane_base;
  logic        pack_full;
  logic        pack_empty;
  logic        byte_accept;
  logic        word_move;
  logic [31:0] word_out;

  // Single-word holding register between the packer and the FIFO port.
  logic        hold_full_reg;
  logic [31:0] hold_data_reg;
  logic        hold_load;
  logic        overflow_evt;

  // Channel handshake state.
  logic [1:0]  act_reg;
  logic [23:0] size_reg;
  logic [23:0] wr_cnt_reg;
  logic        wr_stb;
  logic        flush_drained;
  logic        chan_release;
  logic        chan_acquire;

  // Statistics.
  logic                 frame_done_reg;
  logic [CNT_WIDTH-1:0] frame_cnt_reg;
  logic [CNT_WIDTH-1:0] overflow_cnt_reg;

  // FSM-derived controls.
  logic enable_dma;
  logic frame_end;

  assign pack_full   = (pack_cnt_reg == 3'd4);
  assign pack_empty  = (pack_cnt_reg == 3'd0);
  assign byte_accept = (state_reg == ST_CAPTURE) && i_cam_href && i_cam_valid;

  // A full packer always hands off; in FLUSH any leftover bytes are padded
  // and handed off as the final word of the frame.
  assign word_move = pack_full || ((state_reg == ST_FLUSH) && !pack_empty);

  // Lanes beyond the byte count carry the pad value (only matters for a
  // partial word during flush; a full packer has every lane valid).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_out[31-8*gi -: 8] = (3'(gi) < pack_cnt_reg) ?
                                      pack_data_reg[31-8*gi -: 8] : PAD_BYTE;
    end
  endgenerate

  // Write only when a word is waiting, a channel is held and it has room.
  assign wr_stb = hold_full_reg && (act_reg != 2'b00) && (wr_cnt_reg < size_reg);

  // Nothing left to write for this frame.
  assign flush_drained = (state_reg == ST_FLUSH) && !hold_full_reg && pack_empty;

  assign chan_release = (act_reg != 2'b00) &&
                        ((wr_cnt_reg >= size_reg) || flush_drained);

  // Grabbing a channel we would immediately hand back is pointless, so an
  // already drained flush does not acquire.
  assign chan_acquire = (act_reg == 2'b00) && (i_wr_rdy != 2'b00) &&
                        (state_reg != ST_IDLE) && !flush_drained;

  // A finished word lands in the holding register if it is free or being
  // written out this very cycle; otherwise the new word is lost.
  assign hold_load    = word_move && (!hold_full_reg || wr_stb);
  assign overflow_evt = word_move && hold_full_reg && !wr_stb;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; i_enable only gates leaving IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_enable && i_cam_vsync) state_next = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (!i_cam_vsync) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (i_cam_vsync) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pack_empty && !hold_full_reg && (act_reg == 2'b00)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: DMA enable while capturing/flushing, end-of-frame event.
  always_comb begin
    enable_dma = (state_reg == ST_CAPTURE) || (state_reg == ST_FLUSH);
    frame_end  = (state_reg == ST_FLUSH) && (state_next == ST_IDLE);
  end

  // Packer next state: a byte arriving while a full word leaves starts the
  // next word in lane 0.
  always_comb begin
    pack_cnt_next  = pack_cnt_reg;
    pack_data_next = pack_data_reg;
    lane_base      = pack_cnt_reg[1:0];
    if (word_move) begin
      pack_cnt_next = 3'd0;
      lane_base     = 2'd0;
    end
    if (byte_accept) begin
      pack_data_next[{~lane_base, 3'b000} +: 8] = i_cam_data;
      pack_cnt_next = {1'b0, lane_base} + 3'd1;
    end
  end

  // Packer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_cnt_reg  <= 3'd0;
      pack_data_reg <= 32'd0;
    end else begin
      pack_cnt_reg  <= pack_cnt_next;
      pack_data_reg <= pack_data_next;
    end
  end

  // Holding register: load a new word, or empty it when it is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= 32'd0;
    end else if (hold_load) begin
      hold_full_reg <= 1'b1;
      hold_data_reg <= word_out;
    end else if (wr_stb) begin
      hold_full_reg <= 1'b0;
    end
  end

  // Channel acquire/release and per-channel word count; channel 0 wins ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_reg    <= 2'b00;
      size_reg   <= 24'd0;
      wr_cnt_reg <= 24'd0;
    end else if (chan_acquire) begin
      act_reg    <= i_wr_rdy[0] ? 2'b01 : 2'b10;
      size_reg   <= i_wr_size;
      wr_cnt_reg <= 24'd0;
    end else if (chan_release) begin
      act_reg    <= 2'b00;
    end else if (wr_stb) begin
      wr_cnt_reg <= wr_cnt_reg + 24'd1;
    end
  end

  // Frame-done pulse, wrapping frame counter, saturating overflow counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done_reg   <= 1'b0;
      frame_cnt_reg    <= '0;
      overflow_cnt_reg <= '0;
    end else begin
      frame_done_reg <= frame_end;
      if (frame_end) begin
        frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
      end
      if (overflow_evt && (overflow_cnt_reg != {CNT_WIDTH{1'b1}})) begin
        overflow_cnt_reg <= overflow_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign o_enable_dma     = enable_dma;
  assign o_wr_act         = act_reg;
  assign o_wr_stb         = wr_stb;
  assign o_wr_data        = hold_data_reg;
  assign o_frame_done     = frame_done_reg;
  assign o_frame_count    = frame_cnt_reg;
  assign o_overflow_count = overflow_cnt_reg;

endmodule

// File: doc/sf_camera_capture.md
Name: sf_camera_capture

Overview:
- Upstream capture stage of the SF camera path; the block sits between the camera pixel pins and the ping-pong FIFO write port.
- It packs 8-bit camera bytes, qualified by frame and line syncs, into 32-bit words. It then writes them into the ping-pong FIFO that the DMA stage (ppfifo-to-memory writer) drains.
- It also drives the DMA enable and reports frame and overflow statistics.

Parameters:
- PAD_BYTE, 8'h00, fill value for unused byte lanes of a partial final word.
- CNT_WIDTH, 16, width of frame and overflow counters.

Ports:
- clk  in  1  system clock; all camera inputs are already synchronous to it.
- rst  in  1  reset; asynchronous, active-low.
- i_enable  in  1  capture enable.
- i_cam_vsync  in  1  high = vertical blank; low = frame active.
- i_cam_href  in  1  high = line active.
- i_cam_valid  in  1  byte strobe; at most one per clk.
- i_cam_data  in  8  pixel byte.
- o_enable_dma  out  1  high while a frame is being captured or flushed.
- i_wr_rdy  in  2  ping-pong FIFO channel ready flags.
- o_wr_act  out  2  channel activate, one-hot or zero.
- i_wr_size  in  24  words available in the activated channel.
- o_wr_stb  out  1  write strobe, one word per high cycle.
- o_wr_data  out  32  write data.
- o_frame_done  out  1  one-cycle pulse after the final word of a frame is written.
- o_frame_count  out  CNT_WIDTH  completed frames, wraps.
- o_overflow_count  out  CNT_WIDTH  dropped words, saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous): every output is 0, FSM in IDLE, packer empty, holding register empty, counters 0.
- Capture FSM:
  - IDLE → WAIT_VS when i_enable=1 and i_cam_vsync=1.
  - WAIT_VS → CAPTURE when i_cam_vsync falls to 0.
  - CAPTURE → FLUSH when i_cam_vsync rises to 1.
  - FLUSH → IDLE once the packer and holding register are empty and o_wr_act=0.
  - Dropping i_enable mid-frame does not abort the frame; it only blocks re-entry from IDLE.
  - o_enable_dma=1 in CAPTURE and FLUSH.
- Packing:
  - A byte is accepted only in CAPTURE with i_cam_href=1 and i_cam_valid=1.
  - First byte goes to [31:24], then [23:16], [15:8], [7:0].
  - On the 4th accepted byte the word moves into the single holding register on the next edge.
  - Byte count resets per frame, not per line.
- Flush:
  - On entering FLUSH, a partially filled packer (1–3 bytes) is completed with PAD_BYTE in the remaining low lanes and moved to the holding register.
  - An empty packer produces no word.
- Channel acquire:
  - When o_wr_act=0 and i_wr_rdy≠0, the block asserts o_wr_act on the next edge.
  - Channel 0 is preferred when both ready bits are set.
  - The block latches i_wr_size on that same edge and clears the word count.
  - Acquisition happens in any state except IDLE.
- Write:
  - o_wr_stb=1 for one cycle when the holding register is full, a channel is active, and count < latched size.
  - o_wr_data = holding register.
  - The holding register empties on that same edge.
- Release: o_wr_act returns to 0 on the edge after count reaches latched size, or in FLUSH once the holding register is empty and the packer is empty. A latched size of 0 releases immediately with no strobe.
- Overflow:
  - A new word is ready to move into the holding register while it is still full and not being strobed that cycle: the new word is dropped and o_overflow_count increments.
  - If the strobe and the new word coincide, the holding register takes the new word; no drop.
- Frame done:
  - Raised on the FLUSH → IDLE transition, as a single-cycle pulse.
  - o_frame_count increments on the same edge.
- Latency: last byte in → o_wr_stb no earlier than 2 clk after, given an active channel.

Test Plan:
- Single-channel fill: rdy=2'b01, size=4, one frame of bytes 0x00..0x0F → act=01, four strobes with data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; act drops; frame_done=1; frame_count=1.
- Ping-pong: rdy=2'b11, size=2, 16 bytes → ch0 receives the first two words; after release, ch1 is activated and receives the next two; no overflow.
- Partial flush: 6 bytes, then vsync high → words 0x00010203 and 0x04050000; FSM returns to IDLE; frame_done pulses once.
- Overflow: rdy=0 for a 12-byte frame, then rdy=01 with size=8 → only 0x00010203 is written; overflow_count=2.
- Href gating and size 0: valid bytes with href=0 are ignored (no words); a channel granted with size=0 releases without strobes, and the other ready channel is taken next.
- Reset mid-frame: rst low during CAPTURE with act=01 → act, stb, enable_dma and counters all 0 immediately, without waiting for a clk edge. After release, capture waits for a full vsync high→low before accepting bytes.
